fp_sequencer: RTL
=================

Name: fp_sequencer

Overview:
- Sequences debounced front-panel commands (clear, extended address load, address load, deposit, examine, continue) into PC/field register updates, single-cycle memory transactions and CPU run/step pulses.
- Sits between the front_panel switch conditioner and the memory/CPU core.
- Owns the panel PC, IF/DF fields and the panel MB copy shown by D_mux.
- Arbitrates simultaneous command pulses and rejects panel memory commands while the CPU runs.

Parameters:
- TIMEOUT_CYC, 15: cycles to wait for mem_ack before abort (used only when FP_TIMEOUT_EN is defined).
- PC_RESET, 12'o0200: panel PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sr  in  [0:11]  switch register.
- cleard  in  1  one-cycle clear command pulse.
- extd_addrd  in  1  one-cycle extended-address-load pulse.
- addr_loadd  in  1  one-cycle address-load pulse.
- depd  in  1  one-cycle deposit pulse.
- examd  in  1  one-cycle examine pulse.
- contd  in  1  one-cycle continue pulse.
- sing_step  in  1  single-step switch level.
- run_ff  in  1  CPU running flag.
- mem_ack  in  1  memory transaction done; mem_rdata is valid in the same cycle.
- mem_rdata  in  [0:11]  memory read data.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  [0:14]  {ifield, pc}.
- mem_wdata  out  [0:11]  write data.
- pc  out  [0:11]  panel PC.
- ifield  out  [0:2]  instruction field.
- dfield  out  [0:2]  data field.
- mb  out  [0:11]  last examined or deposited word.
- cpu_clear  out  1  one-cycle initialize pulse to the CPU.
- run_start  out  1  one-cycle start-run pulse.
- step_start  out  1  one-cycle single-instruction pulse.
- busy  out  1  sequencer not in IDLE.
- err  out  1  sticky timeout flag (tied 0 without FP_TIMEOUT_EN).

Behaviour:
- Reset (async, active-low) forces all outputs and registers to these values:
  - state = IDLE; pc = PC_RESET; ifield = 0; dfield = 0; mb = 0.
  - mem_req, mem_we, cpu_clear, run_start, step_start, busy, err = 0.
  - mem_wdata = 0; mem_addr = {0, PC_RESET}.
- State machine: IDLE, CLR, XA, LA, DEP, EXAM, CONT.
- Command acceptance:
  - Commands are sampled only in IDLE.
  - Priority when several pulses arrive in the same cycle: cleard > extd_addrd > addr_loadd > depd > examd > contd. Lower-priority pulses in that cycle are discarded.
  - Pulses arriving while busy=1 are dropped, with one exception: cleard in DEP or EXAM. It deasserts mem_req the next cycle, ignores any late mem_ack and goes to CLR.
- Commands while run_ff=1:
  - extd_addrd, addr_loadd, depd, examd and contd are ignored; state stays IDLE.
  - cleard is still accepted.
- CLR: cpu_clear=1 for exactly one cycle, then IDLE. PC, fields and mb are unchanged.
- XA: ifield <= sr[6:8], dfield <= sr[9:11]; one cycle, then IDLE.
- LA: pc <= sr; one cycle, then IDLE.
- DEP:
  - On entry: mem_req=1, mem_we=1, mem_wdata=sr (captured at accept), mem_addr={ifield,pc}.
  - On mem_ack: mem_req=0 the next cycle, mb <= captured sr, pc <= pc+1, then IDLE.
- EXAM:
  - On entry: mem_req=1, mem_we=0.
  - On mem_ack: mb <= mem_rdata, pc <= pc+1, then IDLE.
- Minimum transaction latency is 3 cycles (accept, request, ack in the same cycle as the request) before busy=0.
- PC increment is modulo 4096: 7777 -> 0000. ifield does not carry.
- mem_addr is stable for the whole time mem_req is high; sr changes mid-transaction have no effect.
- CONT:
  - If sing_step=1: step_start=1 for one cycle.
  - Otherwise: run_start=1 for one cycle.
  - Then IDLE.
- busy = (state != IDLE).

Optional Feature:
- FP_TIMEOUT_EN defined:
  - A 4-bit-or-wider counter runs in DEP and EXAM.
  - If mem_ack is absent after TIMEOUT_CYC cycles with mem_req high: drop mem_req, set err=1 (sticky), leave pc and mb unchanged, go to IDLE.
  - err clears only on CLR or reset.
- Not defined: no counter exists; DEP and EXAM wait indefinitely for mem_ack; err is tied 0.

Decomposition:
- Shared package (parameters.v style include):
  - state encodings FP_IDLE..FP_CONT;
  - PC_RESET default;
  - command-priority index constants.
- One natural sub-module: fp_cmd_arbiter.
  - Combinational priority encoder plus run_ff gating.
  - Outputs a one-hot accepted command to the sequencer FSM.

Test Plan:
- Reset low, then high; addr_loadd with sr=2525 -> pc=2525 after 1 cycle, busy returns to 0.
- extd_addrd with sr=0073 -> ifield=7, dfield=3. Then depd with sr=1234 -> one write at mem_addr=7:2525, data 1234; mb=1234; pc=2526.
- Load pc=7777, examd, memory returns 4321 -> mb=4321, pc=0000, ifield unchanged.
- depd and examd asserted in the same cycle -> only the write occurs. examd pulsed during the deposit wait -> dropped, exactly one transaction.
- contd with sing_step=1 -> step_start high 1 cycle. contd with run_ff=1 -> no pulse. cleard during EXAM -> mem_req drops, cpu_clear pulses once.
- FP_TIMEOUT_EN defined, mem_ack never asserted, examd -> mem_req high 15 cycles, then err=1, pc unchanged. Not defined -> mem_req remains high.

Source files
------------

// File: rtl/fp_sequencer_pkg.sv
// Shared types and constants for the front-panel command sequencer.
package fp_sequencer_pkg;

  typedef enum logic [2:0] {
    FP_IDLE = 3'd0,
    FP_CLR  = 3'd1,
    FP_XA   = 3'd2,
    FP_LA   = 3'd3,
    FP_DEP  = 3'd4,
    FP_EXAM = 3'd5,
    FP_CONT = 3'd6
  } fp_state_e;

  localparam logic [0:11] FP_PC_RESET = 12'o0200;

  // Command indices; a lower index wins when several pulses coincide.
  localparam int unsigned CMD_CLR  = 0;
  localparam int unsigned CMD_XA   = 1;
  localparam int unsigned CMD_LA   = 2;
  localparam int unsigned CMD_DEP  = 3;
  localparam int unsigned CMD_EXAM = 4;
  localparam int unsigned CMD_CONT = 5;
  localparam int unsigned CMD_N    = 6;

  typedef struct packed {
    logic        we;
    logic [0:14] addr;
    logic [0:11] wdata;
  } fp_mem_txn_t;

endpackage

// File: rtl/fp_cmd_arbiter.sv
// Priority-encodes the debounced panel pulses into a one-hot accepted command.
// While the CPU runs only clear survives.
module fp_cmd_arbiter
  import fp_sequencer_pkg::*;
(
  input  logic             i_cleard,
  input  logic             i_extd_addrd,
  input  logic             i_addr_loadd,
  input  logic             i_depd,
  input  logic             i_examd,
  input  logic             i_contd,
  input  logic             i_run_ff,
  output logic [CMD_N-1:0] o_cmd_c
);

  logic [CMD_N-1:0] w_req;

  always_comb begin
    w_req           = '0;
    w_req[CMD_CLR]  = i_cleard;
    w_req[CMD_XA]   = i_extd_addrd & ~i_run_ff;
    w_req[CMD_LA]   = i_addr_loadd & ~i_run_ff;
    w_req[CMD_DEP]  = i_depd       & ~i_run_ff;
    w_req[CMD_EXAM] = i_examd      & ~i_run_ff;
    w_req[CMD_CONT] = i_contd      & ~i_run_ff;
    // Isolate the lowest set bit: highest-priority request only.
    o_cmd_c = w_req & (~w_req + CMD_N'(1));
  end

endmodule

// File: rtl/fp_sequencer.sv
// Front-panel sequencer: panel PC/IF/DF/MB, single memory transactions, CPU pulses.
// Define FP_TIMEOUT_EN to abort memory transactions that are never acknowledged.
module fp_sequencer
  import fp_sequencer_pkg::*;
#(
  parameter logic [0:11] PC_RESET = FP_PC_RESET
`ifdef FP_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 15
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:11] sr,
  input  logic        cleard,
  input  logic        extd_addrd,
  input  logic        addr_loadd,
  input  logic        depd,
  input  logic        examd,
  input  logic        contd,
  input  logic        sing_step,
  input  logic        run_ff,
  input  logic        mem_ack,
  input  logic [0:11] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [0:14] mem_addr,
  output logic [0:11] mem_wdata,
  output logic [0:11] pc,
  output logic [0:2]  ifield,
  output logic [0:2]  dfield,
  output logic [0:11] mb,
  output logic        cpu_clear,
  output logic        run_start,
  output logic        step_start,
  output logic        busy,
  output logic        err
);

`ifdef FP_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYC) > 4) ? $clog2(TIMEOUT_CYC) : 4;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
`endif

  fp_state_e        r_state, w_state_nxt;
  logic [0:11]      r_pc, w_pc_nxt;
  logic [0:2]       r_ifield, w_ifield_nxt;
  logic [0:2]       r_dfield, w_dfield_nxt;
  logic [0:11]      r_mb, w_mb_nxt;
  logic             r_mem_req, w_mem_req_nxt;
  fp_mem_txn_t      r_txn, w_txn_nxt;
  logic             r_cpu_clear, w_cpu_clear_nxt;
  logic             r_run_start, w_run_start_nxt;
  logic             r_step_start, w_step_start_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_err, w_err_nxt;
  logic [CMD_N-1:0] w_cmd_c;

  fp_cmd_arbiter u_arb (
    .i_cleard     (cleard),
    .i_extd_addrd (extd_addrd),
    .i_addr_loadd (addr_loadd),
    .i_depd       (depd),
    .i_examd      (examd),
    .i_contd      (contd),
    .i_run_ff     (run_ff),
    .o_cmd_c      (w_cmd_c)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifield_nxt     = r_ifield;
    w_dfield_nxt     = r_dfield;
    w_mb_nxt         = r_mb;
    w_mem_req_nxt    = r_mem_req;
    w_txn_nxt        = r_txn;
    w_cpu_clear_nxt  = 1'b0;
    w_run_start_nxt  = 1'b0;
    w_step_start_nxt = 1'b0;
    w_err_nxt        = r_err;
`ifdef FP_TIMEOUT_EN
    w_tmo_cnt_nxt    = r_tmo_cnt;
`endif
    unique case (r_state)
      FP_IDLE: begin
        if (w_cmd_c[CMD_CLR]) begin
          w_state_nxt     = FP_CLR;
          w_cpu_clear_nxt = 1'b1;
          w_err_nxt       = 1'b0;
        end else if (w_cmd_c[CMD_XA]) begin
          w_state_nxt  = FP_XA;
          w_ifield_nxt = sr[6:8];
          w_dfield_nxt = sr[9:11];
        end else if (w_cmd_c[CMD_LA]) begin
          w_state_nxt = FP_LA;
          w_pc_nxt    = sr;
        end else if (w_cmd_c[CMD_DEP] || w_cmd_c[CMD_EXAM]) begin
          // Address and write data are frozen here for the whole transaction.
          w_state_nxt    = w_cmd_c[CMD_DEP] ? FP_DEP : FP_EXAM;
          w_mem_req_nxt  = 1'b1;
          w_txn_nxt.we   = w_cmd_c[CMD_DEP];
          w_txn_nxt.addr = {r_ifield, r_pc};
          if (w_cmd_c[CMD_DEP]) w_txn_nxt.wdata = sr;
`ifdef FP_TIMEOUT_EN
          w_tmo_cnt_nxt  = '0;
`endif
        end else if (w_cmd_c[CMD_CONT]) begin
          w_state_nxt      = FP_CONT;
          w_step_start_nxt = sing_step;
          w_run_start_nxt  = ~sing_step;
        end
      end
      FP_DEP, FP_EXAM: begin
        if (w_cmd_c[CMD_CLR]) begin
          w_state_nxt     = FP_CLR;
          w_mem_req_nxt   = 1'b0;
          w_cpu_clear_nxt = 1'b1;
          w_err_nxt       = 1'b0;
        end else if (mem_ack) begin
          w_state_nxt   = FP_IDLE;
          w_mem_req_nxt = 1'b0;
          w_pc_nxt      = r_pc + 12'd1;
          w_mb_nxt      = (r_state == FP_DEP) ? r_txn.wdata : mem_rdata;
        end
`ifdef FP_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt   = FP_IDLE;
          w_mem_req_nxt = 1'b0;
          w_err_nxt     = 1'b1;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
`endif
      end
      default: w_state_nxt = FP_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != FP_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= FP_IDLE;
      r_pc         <= PC_RESET;
      r_ifield     <= '0;
      r_dfield     <= '0;
      r_mb         <= '0;
      r_mem_req    <= 1'b0;
      r_txn        <= '{we: 1'b0, addr: {3'b000, PC_RESET}, wdata: 12'd0};
      r_cpu_clear  <= 1'b0;
      r_run_start  <= 1'b0;
      r_step_start <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
`ifdef FP_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ifield     <= w_ifield_nxt;
      r_dfield     <= w_dfield_nxt;
      r_mb         <= w_mb_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_txn        <= w_txn_nxt;
      r_cpu_clear  <= w_cpu_clear_nxt;
      r_run_start  <= w_run_start_nxt;
      r_step_start <= w_step_start_nxt;
      r_busy       <= w_busy_nxt;
      r_err        <= w_err_nxt;
`ifdef FP_TIMEOUT_EN
      r_tmo_cnt    <= w_tmo_cnt_nxt;
`endif
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_txn.we;
  assign mem_addr   = r_txn.addr;
  assign mem_wdata  = r_txn.wdata;
  assign pc         = r_pc;
  assign ifield     = r_ifield;
  assign dfield     = r_dfield;
  assign mb         = r_mb;
  assign cpu_clear  = r_cpu_clear;
  assign run_start  = r_run_start;
  assign step_start = r_step_start;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule
